order_msg_tx: RTL
=================

// Module: order_msg_tx
// PURPOSE
//  Order-entry transmitter: packs order fields into the 48-bit order word carried on the
//  core's eth_rx_data/eth_rx_valid/eth_rx_ready interface and drives that interface.
//  It sits on the order source side (gateway/strategy model) facing top_level.
//  A small FIFO buffers orders, and a TX FSM emits one word per valid/ready handshake.
//  A 4-bit wrapping sequence number is stamped on each word.
// PARAMETERS
//  FIFO_DEPTH  4  order FIFO entries; power of 2, >=2
//  GAP_CYCLES  1  idle cycles after each TX handshake before next pop; 0..15
// PORTS
//  clk         in   1   clock; all logic on rising edge
//  rst         in   1   synchronous reset, active-high
//  ord_valid   in   1   order fields valid
//  ord_ready   out  1   block can accept an order (=!fifo_full && !rst)
//  ord_id      in   16  order id
//  ord_type    in   2   order type
//  ord_side    in   2   side
//  ord_price   in   8   price
//  ord_qty     in   8   quantity; 0 = malformed
//  ord_symbol  in   8   symbol
//  tx_data     out  48  {ord_id,ord_type,ord_side,ord_price,ord_qty,ord_symbol,seq[3:0]}
//  tx_valid    out  1   tx_data valid
//  tx_ready    in   1   sink accepts word
//  seq_num     out  4   seq value to be stamped on next popped word
//  sent_count  out  16  words handshaken on tx; wraps 65535->0
//  err_count   out  8   orders dropped for qty==0; saturates at 255
//  busy        out  1   FSM!=IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: the synchronous reset flushes the FIFO and sets state=IDLE.
//   tx_data, tx_valid, seq_num, sent_count, err_count and busy are all 0.
//   ord_ready is 0 in any cycle where rst=1.
//   A reset mid-SEND drops the in-flight word; no handshake is counted.
//  Accept: ord_valid&&ord_ready at an edge.
//   qty!=0: the 44 field bits are written to the FIFO.
//   qty==0: the order is consumed but not stored; err_count+1 (saturating).
//  FIFO: push and pop in the same cycle leave count unchanged. There is no bypass path.
//   When full, ord_ready=0. A pop frees the slot, and ord_ready rises the next cycle.
//  FSM states IDLE, SEND, GAP:
//   IDLE: if FIFO non-empty, pop and register tx_data={fields,seq_num}.
//    At the same edge seq_num+1 (wraps 15->0), tx_valid<=1 and the FSM goes to SEND.
//   SEND: tx_data and tx_valid are held stable while !tx_ready.
//    On tx_valid&&tx_ready: tx_valid<=0, sent_count+1, and the FSM goes to GAP.
//    If GAP_CYCLES==0 it goes straight to IDLE instead.
//   GAP: stays GAP_CYCLES cycles, then goes to IDLE.
//  Latency: an accept at edge N into an empty FIFO with the FSM in IDLE gives tx_valid=1
//   after edge N+1. Minimum spacing between TX handshakes is GAP_CYCLES+2 cycles.
//  Capacity: FIFO_DEPTH buffered words plus 1 held in SEND.
//  Order: words leave in acceptance order. Seq is contiguous across dropped (qty==0) orders.
// TESTING
//  T1 single: id 5678 type0 side0 price10 qty20 sym30, tx_ready=1
//   -> tx_valid 2 cycles after accept, tx_data=48'h567801020300, sent_count=1.
//  T2 backpressure: tx_ready=0 for 5 cycles during SEND
//   -> tx_data/tx_valid stable, sent_count unchanged; tx_ready=1 -> exactly one handshake.
//  T3 fill: tx_ready=0, offer 6 orders
//   -> 5 accepted (1 in SEND + 4 FIFO), then ord_ready=0.
//   Release tx_ready -> 5 words in order, seq 0..4, handshakes 3 cycles apart (GAP_CYCLES=1).
//  T4 malformed: qty=0 order -> no tx_valid, err_count=1; next good order carries seq 0.
//  T5 wrap: 17 orders id AABB type1 side1 price40 qty50 sym60
//   -> 17th tx_data=48'hAABB5405060_0 (seq 0), sent_count=17.
//  T6 reset mid-op: rst=1 while tx_valid=1 with 2 words queued
//   -> next cycle tx_valid=0, busy=0, seq_num=0, counters 0, no stale words after reset.

Source files
------------

// File: rtl/order_msg_tx_if.sv
// rtl/order_msg_tx_if.sv - order field input and 48-bit order word output handshake bundle
interface order_msg_tx_if;
  logic        ord_valid;
  logic        ord_ready;
  logic [15:0] ord_id;
  logic [1:0]  ord_type;
  logic [1:0]  ord_side;
  logic [7:0]  ord_price;
  logic [7:0]  ord_qty;
  logic [7:0]  ord_symbol;
  logic [47:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    input  ord_valid, ord_id, ord_type, ord_side, ord_price, ord_qty, ord_symbol, tx_ready,
    output ord_ready, tx_data, tx_valid
  );

  modport slave (
    output ord_valid, ord_id, ord_type, ord_side, ord_price, ord_qty, ord_symbol, tx_ready,
    input  ord_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/order_msg_tx.sv
// rtl/order_msg_tx.sv - order FIFO plus TX FSM that stamps a wrapping sequence number on each word
module order_msg_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  order_msg_tx_if.master bus,
  output logic [3:0]    seq_num,
  output logic [15:0]   sent_count,
  output logic [7:0]    err_count,
  output logic          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state;

  logic [43:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    gap_cnt;
  logic          fifo_full, fifo_empty, accept, push, pop;
  logic [43:0]   din;

  assign fifo_full     = (count == DEPTH_L);
  assign fifo_empty    = (count == '0);
  assign bus.ord_ready = !fifo_full && !rst;
  assign accept        = bus.ord_valid && bus.ord_ready;
  assign push          = accept && (bus.ord_qty != 8'd0);
  assign pop           = (state == IDLE) && !fifo_empty;
  assign din           = {bus.ord_id, bus.ord_type, bus.ord_side,
                          bus.ord_price, bus.ord_qty, bus.ord_symbol};
  assign busy          = (state != IDLE) || !fifo_empty;

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && (bus.ord_qty == 8'd0) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.tx_data  <= 48'd0;
      bus.tx_valid <= 1'b0;
      seq_num      <= 4'd0;
      sent_count   <= 16'd0;
      gap_cnt      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.tx_data  <= {mem[rd_ptr], seq_num};
            bus.tx_valid <= 1'b1;
            seq_num      <= seq_num + 4'd1;
            state        <= SEND;
          end
        end
        SEND: begin
          // tx_valid is always 1 here, so tx_ready alone completes the handshake
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            sent_count   <= sent_count + 16'd1;
            gap_cnt      <= GAP_LAST;
            state        <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
